// File: rtl/output_port_arbiter_if.sv
// Port bundle between an output_port_arbiter and its requesters and downstream link.
// The arbiter takes the master view; the router or testbench side takes the slave view.
interface output_port_arbiter_if #(
  parameter int PACKET_WIDTH = 64,
  parameter int NUM_REQ      = 5,
  parameter int CNT_WIDTH    = 16
);
  logic                            polarity;
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]              req_grant;
  logic                            so;
  logic [PACKET_WIDTH-1:0]         dout;
  logic                            ro;
  logic [1:0]                      obuf_full;
  logic [CNT_WIDTH-1:0]            pkt_count;

  modport master (
    input  polarity, req_valid, req_data, ro,
    output req_grant, so, dout, obuf_full, pkt_count
  );

  modport slave (
    output polarity, req_valid, req_data, ro,
    input  req_grant, so, dout, obuf_full, pkt_count
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Round-robin arbiter feeding a one-packet-per-VC output buffer. Polarity picks the VC
// being refilled; the opposite VC drives the link, so the two never collide.
module output_port_arbiter #(
  parameter int PACKET_WIDTH = 64,
  parameter int NUM_REQ      = 5,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output_port_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                    vc_in;
  logic                    vc_out;
  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      above_rr;
  logic [NUM_REQ-1:0]      eligible_hi;
  logic [IDX_W-1:0]        rr_cur;
  logic [IDX_W-1:0]        grant_idx;
  logic [PACKET_WIDTH-1:0] grant_data;
  logic                    grant_any;
  logic                    send;
  logic [1:0]              full_vec;
  logic [PACKET_WIDTH-1:0] buf_data [2];
  logic [IDX_W-1:0]        rr_vec [2];
  logic [CNT_WIDTH-1:0]    pkt_count_reg;

  assign vc_in  = bus.polarity;
  assign vc_out = ~bus.polarity;
  assign rr_cur = rr_vec[vc_in];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign eligible[gi] = bus.req_valid[gi] &&
                          (bus.req_data[gi*PACKET_WIDTH + PACKET_WIDTH - 1] == vc_in);
    assign above_rr[gi] = (IDX_W'(gi) > rr_cur);
    assign bus.req_grant[gi] = grant_any && (grant_idx == IDX_W'(gi));
  end

  // Requesters past the pointer take priority; otherwise wrap to the lowest index.
  assign eligible_hi = eligible & above_rr;

  always_comb begin
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[k]) grant_idx = IDX_W'(k);
    end
    if (|eligible_hi) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (eligible_hi[k]) grant_idx = IDX_W'(k);
      end
    end
  end

  assign grant_data = bus.req_data[int'(grant_idx)*PACKET_WIDTH +: PACKET_WIDTH];

  // Gated by reset so nothing is granted or sent while the port is held in reset.
  assign grant_any = reset && !full_vec[vc_in] && (|eligible);
  assign send      = reset && full_vec[vc_out] && bus.ro;

  assign bus.so        = send;
  assign bus.dout      = send ? buf_data[vc_out] : '0;
  assign bus.obuf_full = full_vec;
  assign bus.pkt_count = pkt_count_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_vc
    logic [PACKET_WIDTH-1:0] data_reg;
    logic                    full_reg;
    logic [IDX_W-1:0]        rr_reg;
    logic                    load;
    logic                    drain;

    assign load  = grant_any && (vc_in == 1'(gi));
    assign drain = send && (vc_out == 1'(gi));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_reg <= '0;
        full_reg <= 1'b0;
        rr_reg   <= IDX_W'(NUM_REQ - 1);
      end else if (load) begin
        data_reg <= grant_data;
        full_reg <= 1'b1;
        rr_reg   <= grant_idx;
      end else if (drain) begin
        full_reg <= 1'b0;
      end
    end

    assign full_vec[gi] = full_reg;
    assign buf_data[gi] = data_reg;
    assign rr_vec[gi]   = rr_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count_reg <= '0;
    end else if (send && (pkt_count_reg != '1)) begin
      pkt_count_reg <= pkt_count_reg + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench: the stimulus process predicts grants, sends and counts with a
// queue-level model; a negedge monitor pops and compares whatever the DUT presents.
module tb_output_port_arbiter;
  localparam int PW  = 64;
  localparam int NR  = 5;
  localparam int CW  = 16;
  localparam int SCW = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  output_port_arbiter_if #(.PACKET_WIDTH(PW), .NUM_REQ(NR), .CNT_WIDTH(CW))  bus ();
  output_port_arbiter_if #(.PACKET_WIDTH(PW), .NUM_REQ(NR), .CNT_WIDTH(SCW)) sat_bus ();

  assign sat_bus.polarity  = bus.polarity;
  assign sat_bus.req_valid = bus.req_valid;
  assign sat_bus.req_data  = bus.req_data;
  assign sat_bus.ro        = bus.ro;

  output_port_arbiter #(.PACKET_WIDTH(PW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Narrow-counter copy so saturation is reachable within a short run.
  output_port_arbiter #(.PACKET_WIDTH(PW), .NUM_REQ(NR), .CNT_WIDTH(SCW)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sat_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester table and reference model state
  logic          req_v [NR];
  logic [PW-1:0] req_d [NR];
  int            refill_mode = 0;
  logic          pol_next = 1'b0;
  logic          m_full [2];
  logic [PW-1:0] m_data [2];
  int            m_rr [2];
  int            m_cnt;

  int            exp_grant_q [$];
  logic [PW-1:0] exp_dout_q [$];
  int            exp_cnt_q [$];
  logic [1:0]    exp_full_q [$];

  bit mon_en = 1'b0;
  bit cnt_pending = 1'b0;
  int pend_cnt = 0;

  function automatic logic [PW-1:0] new_pkt(input int vc);
    return {vc[0], 31'($urandom()), 32'($urandom())};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = '0;
      m_rr[i]   = NR - 1;
    end
    m_cnt = 0;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < NR; k++) begin
      req_v[k] = 1'b0;
      req_d[k] = '0;
    end
  endtask

  task automatic refill(input int k);
    if (refill_mode == 1) begin
      if ($urandom_range(0, 1) == 1) begin
        req_v[k] = 1'b1;
        req_d[k] = new_pkt(int'($urandom_range(0, 1)));
      end
    end else if (refill_mode == 2) begin
      req_v[k] = 1'b1;
      req_d[k] = new_pkt(0);
    end
  endtask

  // One cycle: drive inputs, predict this cycle's outputs, advance the model past the edge.
  task automatic step(input logic ro_v);
    logic [NR*PW-1:0] flat;
    int v;
    int w;
    int g;
    int k;
    @(posedge clk);
    #1;
    if (refill_mode == 1) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_v[i] && $urandom_range(0, 2) == 0) begin
          req_v[i] = 1'b1;
          req_d[i] = new_pkt(int'($urandom_range(0, 1)));
        end
      end
    end
    flat = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = req_v[i];
      flat[i*PW +: PW] = req_d[i];
    end
    bus.req_data = flat;
    bus.polarity = pol_next;
    bus.ro       = ro_v;

    v = pol_next ? 1 : 0;
    w = 1 - v;
    exp_full_q.push_back({m_full[1], m_full[0]});
    g = -1;
    if (!m_full[v]) begin
      for (int i = 1; i <= NR; i++) begin
        k = (m_rr[v] + i) % NR;
        if (req_v[k] && (req_d[k][PW-1] == v[0])) begin
          g = k;
          break;
        end
      end
    end
    if (g >= 0) exp_grant_q.push_back(g);
    if (m_full[w] && ro_v) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      exp_dout_q.push_back(m_data[w]);
      exp_cnt_q.push_back(m_cnt);
      m_full[w] = 1'b0;
    end
    if (g >= 0) begin
      m_data[v] = req_d[g];
      m_full[v] = 1'b1;
      m_rr[v]   = g;
      req_v[g]  = 1'b0;
      refill(g);
    end
    pol_next = ~pol_next;
  endtask

  task automatic align_pol0();
    if (pol_next) step(1'b1);
  endtask

  always @(negedge clk) begin
    if (reset && mon_en) begin
      if (cnt_pending) begin
        check("pkt_count", 64'(bus.pkt_count), 64'(pend_cnt));
        check("pkt_count_sat", 64'(sat_bus.pkt_count), 64'((pend_cnt > 7) ? 7 : pend_cnt));
        cnt_pending = 1'b0;
      end
      if (exp_full_q.size() > 0) check("obuf_full", 64'(bus.obuf_full), 64'(exp_full_q.pop_front()));
      if (bus.req_grant != '0) begin
        if (exp_grant_q.size() == 0) check("grant_unexpected", 64'(bus.req_grant), 64'(0));
        else check("req_grant", 64'(bus.req_grant), 64'(1) << exp_grant_q.pop_front());
      end
      if (bus.so) begin
        if (exp_dout_q.size() == 0) begin
          check("so_unexpected", 64'(bus.so), 64'(0));
        end else begin
          check("dout", bus.dout, exp_dout_q.pop_front());
          pend_cnt    = exp_cnt_q.pop_front();
          cnt_pending = 1'b1;
        end
      end else begin
        check("dout_idle", bus.dout, 64'(0));
      end
    end
  end

  initial begin
    // Held in reset with random traffic on the inputs
    bus.polarity  = 1'b0;
    bus.ro        = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      bus.polarity  = ~bus.polarity;
      bus.req_valid = NR'($urandom());
      for (int i = 0; i < NR; i++) bus.req_data[i*PW +: PW] = new_pkt(int'($urandom_range(0, 1)));
      #3;
      check("rst_so", 64'(bus.so), 64'(0));
      check("rst_req_grant", 64'(bus.req_grant), 64'(0));
    end
    check("rst_obuf_full", 64'(bus.obuf_full), 64'(0));
    check("rst_pkt_count", 64'(bus.pkt_count), 64'(0));
    check("rst_dout", bus.dout, 64'(0));

    model_reset();
    clear_reqs();
    bus.req_valid = '0;
    bus.ro        = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    // First packet: grant at polarity 0, sent next cycle
    pol_next = 1'b0;
    req_v[0] = 1'b1;
    req_d[0] = 64'h0000_0000_0000_00AA;
    step(1'b1);
    step(1'b1);

    // Round-robin with all requesters continuously on VC0
    align_pol0();
    refill_mode = 2;
    for (int i = 0; i < NR; i++) begin
      req_v[i] = 1'b1;
      req_d[i] = new_pkt(0);
    end
    for (int c = 0; c < 12; c++) step(1'b1);
    refill_mode = 0;
    clear_reqs();
    for (int c = 0; c < 3; c++) step(1'b1);

    // VC separation: a VC1 packet is ignored at polarity 0
    align_pol0();
    req_v[2] = 1'b1;
    req_d[2] = new_pkt(1);
    for (int c = 0; c < 4; c++) step(1'b1);

    // Backpressure on VC0 with another VC0 request waiting
    align_pol0();
    req_v[0] = 1'b1;
    req_d[0] = new_pkt(0);
    step(1'b0);
    req_v[1] = 1'b1;
    req_d[1] = new_pkt(0);
    for (int c = 0; c < 6; c++) step(1'b0);
    for (int c = 0; c < 4; c++) step(1'b1);

    // Fill both buffers, then reset mid-operation
    align_pol0();
    req_v[0] = 1'b1;
    req_d[0] = new_pkt(0);
    req_v[1] = 1'b1;
    req_d[1] = new_pkt(1);
    for (int c = 0; c < 3; c++) step(1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_grant_q", 64'(exp_grant_q.size()), 64'(0));
    check("pre_reset_dout_q", 64'(exp_dout_q.size()), 64'(0));
    bus.ro = 1'b1;
    reset  = 1'b0;
    #1;
    check("midrst_obuf_full", 64'(bus.obuf_full), 64'(0));
    check("midrst_so", 64'(bus.so), 64'(0));
    check("midrst_pkt_count", 64'(bus.pkt_count), 64'(0));
    bus.req_valid = '1;
    bus.req_data  = '0;
    #1;
    check("midrst_req_grant", 64'(bus.req_grant), 64'(0));
    exp_grant_q.delete();
    exp_dout_q.delete();
    exp_cnt_q.delete();
    exp_full_q.delete();
    cnt_pending   = 1'b0;
    bus.req_valid = '0;
    bus.ro        = 1'b0;
    model_reset();
    clear_reqs();
    @(negedge clk);
    reset = 1'b1;

    // After release the pointer restarts, so requester 0 wins first
    pol_next = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_v[i] = 1'b1;
      req_d[i] = new_pkt(0);
    end
    for (int c = 0; c < 4; c++) step(1'b1);
    clear_reqs();

    // Random traffic with random backpressure; also drives the narrow counter into saturation
    refill_mode = 1;
    for (int c = 0; c < 600; c++) step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

    @(negedge clk);
    #1;
    check("grant_q_drained", 64'(exp_grant_q.size()), 64'(0));
    check("dout_q_drained", 64'(exp_dout_q.size()), 64'(0));
    check("final_pkt_count", 64'(bus.pkt_count), 64'(m_cnt));
    check("final_sat_count", 64'(sat_bus.pkt_count), 64'((m_cnt > 7) ? 7 : m_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Per-output-port arbiter and output buffer for the mesh router.
- Shares one outgoing link (cw, ccw, ns, sn or pe) among NUM_REQ input-buffer requesters using round-robin.
- Holds one packet per virtual channel (VC0/VC1), and follows the router's even/odd polarity so internal moves and link sends never touch the same VC in the same cycle.
- The router instantiates five of these, one per output direction.

Parameters:
- PACKET_WIDTH, 64, packet width in bits; bit PACKET_WIDTH-1 is the VC bit.
- NUM_REQ, 5, number of requesting input buffers (4 directions + PE).
- CNT_WIDTH, 16, width of the forwarded-packet counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- polarity  input  1  router polarity for this cycle; toggles every cycle.
- req_valid  input  NUM_REQ  requester k holds a packet routed to this port.
- req_data  input  NUM_REQ*PACKET_WIDTH  flattened packets; requester k occupies [k*PACKET_WIDTH +: PACKET_WIDTH].
- req_grant  output  NUM_REQ  one-hot; requester k pops its packet this cycle.
- so  output  1  send-out to the downstream link.
- do  output  PACKET_WIDTH  data-out to the downstream link.
- ro  input  1  downstream ready for the VC being sent this cycle.
- obuf_full  output  2  occupancy of VC0/VC1 output buffers.
- pkt_count  output  CNT_WIDTH  packets forwarded on the link, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both output buffers empty (obuf_full=2'b00), buffer data cleared.
  - RR pointers rr[0] = rr[1] = NUM_REQ-1, pkt_count = 0.
  - Combinational outputs at reset: req_grant=0, so=0, do=0.
  - Packets held in the buffers when reset asserts mid-operation are discarded; no partial send.
- Internal phase (VC v = polarity):
  - Requester k is eligible iff req_valid[k]=1 and req_data[k][PACKET_WIDTH-1]=v.
  - Grants are considered only when obuf_full[v]=0.
  - Search order is rr[v]+1, rr[v]+2, … modulo NUM_REQ; the first eligible requester wins.
  - Winner gets req_grant[k]=1 combinationally in the same cycle.
  - At the clock edge: obuf[v] <= req_data[k], obuf_full[v] <= 1, rr[v] <= k.
  - No eligible requester or obuf_full[v]=1: req_grant=0 and rr[v] unchanged.
  - At most one grant per cycle.
- External phase (VC w = ~polarity):
  - so = obuf_full[w] & ro; do = obuf[w] when so=1, else 0.
  - At the edge where so=1: obuf_full[w] <= 0 and pkt_count increments, saturating at all-ones.
  - ro=0: packet holds in the buffer, so=0, retried on the next cycle with this polarity (2-cycle period).
- Simultaneous events: an internal grant into VC v and an external send from VC w occur in the same cycle with no conflict, because v ≠ w.
- A buffer emptied by a send becomes eligible for refill on the next cycle whose polarity equals that VC.
- Latency: a packet granted in cycle t is first sendable in cycle t+1, which has the opposite polarity and therefore treats it as the external VC. Minimum latency is 1 cycle, grant to so.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants on its VC.
- Requesters must hold req_valid/req_data stable until granted; the arbiter does not latch requests.
- Implementation: requests are masked and rotated with a priority encoder, NUM_REQ is generic, and all state is registered on clk with async clear.

Test Plan:
- Reset check: reset=0 with random inputs → so=0, req_grant=0, obuf_full=00, pkt_count=0; release reset, polarity=0, req_valid=5'b00001 with VC0 packet 0x0000_0000_0000_00AA → req_grant=00001 that cycle; next cycle (polarity=1, ro=1) so=1, do=0x…AA, pkt_count=1.
- Round-robin: all 5 requesters valid on VC0 with ro=1 and polarity toggling → successive VC0 grants go to requester 0,1,2,3,4,0, one every 2 cycles.
- VC separation: requester 2 holds a VC1 packet, polarity=0 → no grant; next cycle with polarity=1 → req_grant=00100, and so for that packet follows at polarity=0.
- Backpressure: obuf VC0 full, ro=0 for 6 cycles → so=0 throughout, no new VC0 grant, obuf_full[0]=1; ro=1 on the next polarity=1 cycle → so=1 and the buffer frees.
- Saturation: preload pkt_count to 16'hFFFE, forward 3 packets → counter reads 16'hFFFF and stays there.
- Mid-operation reset: both buffers full, assert reset for one cycle → obuf_full=00, so=0 immediately (asynchronous), rr reset so requester 0 wins first after release.
